// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ack check.
// Define PS2_TX_TIMEOUT_EN to add a device-response watchdog.
module ps2_host_tx #(
  parameter int CLK_HOLD_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE} state_t;

  localparam logic [31:0] HOLD_LAST = 32'(CLK_HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]  frame_q, frame_d;
  logic        ack_q, ack_d;
  logic        clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d, clk_prev_q, clk_prev_d;
  logic        dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
  logic        clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic        clk_fall;
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wd_cnt_q, wd_cnt_d;
`endif

  assign clk_fall = clk_prev_q & ~clk_sync_q;

  always_comb begin
    clk_meta_d = ps2_clk_in;
    clk_sync_d = clk_meta_q;
    clk_prev_d = clk_sync_q;
    dat_meta_d = ps2_dat_in;
    dat_sync_d = dat_meta_q;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    frame_d    = frame_q;
    ack_d      = ack_q;
    clk_oe_d   = 1'b0;
    dat_oe_d   = dat_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    case (state_q)
      IDLE: begin
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        if (tx_start) begin
          frame_d    = {~^tx_data, tx_data};
          bit_cnt_d  = 4'd0;
          hold_cnt_d = 32'd0;
          busy_d     = 1'b1;
          clk_oe_d   = 1'b1;
          dat_oe_d   = (HOLD_LAST == 32'd0);
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        clk_oe_d = 1'b1;
        if (hold_cnt_q == HOLD_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          state_d  = REQUEST;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
          // start bit goes low together with the final inhibit cycle
          dat_oe_d   = (hold_cnt_d == HOLD_LAST);
        end
      end
      REQUEST, SEND: begin
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd9) begin
            dat_oe_d = ~frame_q[bit_cnt_q];
            state_d  = SEND;
          end else begin
            dat_oe_d = 1'b0;
            state_d  = ACK;
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          ack_d     = ~dat_sync_q;
          bit_cnt_d = 4'd11;
          state_d   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync_q && dat_sync_q) begin
          done_d  = ack_q;
          error_d = ~ack_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    wd_cnt_d = 32'd0;
    if (state_q inside {REQUEST, SEND, ACK, WAIT_IDLE}) begin
      if (wd_cnt_q == TIMEOUT_LAST) begin
        // watchdog wins over any completion arriving in the same cycle
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        error_d  = 1'b1;
        state_d  = IDLE;
      end else begin
        wd_cnt_d = wd_cnt_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= 32'd0;
      bit_cnt_q  <= 4'd0;
      frame_q    <= 9'd0;
      ack_q      <= 1'b0;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_cnt_q   <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      ack_q      <= ack_d;
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      clk_prev_q <= clk_prev_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_cnt_q   <= wd_cnt_d;
`endif
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_error   = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a simple PS/2 device model clocks frames out and acks/nacks.
module tb_ps2_host_tx;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TB_TIMEOUT = 3000;
`else
  localparam int TB_TIMEOUT = 1000000;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       dev_clk, dev_dat;
  logic       line_clk, line_dat;
  logic       ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error;

  int checks = 0;
  int failures = 0;
  int done_count = 0;
  int error_count = 0;
  int both_count = 0;
  int hold_len = 0;
  int dat_rise_at = 0;
  logic prev_clk_oe = 1'b0;

  assign line_clk = dev_clk & ~ps2_clk_oe;
  assign line_dat = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .CLK_HOLD_CYCLES(5000),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .ps2_clk_in(line_clk),
    .ps2_dat_in(line_dat),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  // pulse counters and inhibit-window measurement, sampled mid-cycle
  always @(negedge clk) begin
    if (tx_done) done_count++;
    if (tx_error) error_count++;
    if (tx_done && tx_error) both_count++;
    if (ps2_clk_oe && !prev_clk_oe) begin
      hold_len = 1;
      dat_rise_at = ps2_dat_oe ? 1 : 0;
    end else if (ps2_clk_oe) begin
      hold_len++;
      if (ps2_dat_oe && dat_rise_at == 0) dat_rise_at = hold_len;
    end
    prev_clk_oe = ps2_clk_oe;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    @(negedge clk);
    tx_data = data;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic waitRequest(output logic ok);
    int n = 0;
    while (ps2_clk_oe && n < 6000) begin
      tick(1);
      n++;
    end
    ok = !ps2_clk_oe;
  endtask

  task automatic devEdge(output logic s);
    dev_clk = 1'b0;
    tick(12);
    s = line_dat;
    tick(8);
    dev_clk = 1'b1;
    tick(20);
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic give_ack, output logic [10:0] bits);
    logic ok, s;
    bits = '0;
    applyStimulus(data);
    checkOutput("busy_after_start", {31'd0, tx_busy}, 32'd1);
    waitRequest(ok);
    checkOutput("request_reached", {31'd0, ok}, 32'd1);
    if (!ok) return;
    tick(2);
    bits[0] = line_dat;
    for (int i = 1; i <= 10; i++) begin
      devEdge(s);
      bits[i] = s;
    end
    dev_dat = give_ack ? 1'b0 : 1'b1;
    tick(5);
    devEdge(s);
    dev_dat = 1'b1;
    tick(30);
  endtask

  logic [7:0]  vec_data [4];
  logic        vec_par  [4];
  logic [10:0] bits;
  logic [7:0]  a5;
  logic [4:0]  part;
  int          d0, e0, cnt;
  logic        ok, s;

  initial begin
    vec_data = '{8'hED, 8'h01, 8'h00, 8'hFF};
    vec_par  = '{1'b1, 1'b0, 1'b1, 1'b1};
    reset = 1'b0;
    tx_data = 8'h00;
    tx_start = 1'b0;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    tick(5);
    checkOutput("reset_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    checkOutput("reset_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    checkOutput("reset_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("reset_done", {31'd0, tx_done}, 32'd0);
    checkOutput("reset_error", {31'd0, tx_error}, 32'd0);
    reset = 1'b1;
    tick(5);

    for (int v = 0; v < 4; v++) begin
      d0 = done_count;
      e0 = error_count;
      sendFrame(vec_data[v], 1'b1, bits);
      if (v == 0) begin
        checkOutput("inhibit_len", hold_len, 32'd5000);
        checkOutput("start_bit_cycle", dat_rise_at, 32'd5000);
      end
      checkOutput($sformatf("frame_%02h", vec_data[v]), {21'd0, bits},
                  {21'd0, 1'b1, vec_par[v], vec_data[v], 1'b0});
      checkOutput("done_pulses", done_count - d0, 32'd1);
      checkOutput("error_pulses", error_count - e0, 32'd0);
      checkOutput("busy_dropped", {31'd0, tx_busy}, 32'd0);
    end

    // device leaves data high at the ack edge
    d0 = done_count;
    e0 = error_count;
    sendFrame(8'h55, 1'b0, bits);
    checkOutput("frame_55", {21'd0, bits}, {21'd0, 11'b11_0101_0101_0});
    checkOutput("nack_error", error_count - e0, 32'd1);
    checkOutput("nack_no_done", done_count - d0, 32'd0);
    checkOutput("nack_busy", {31'd0, tx_busy}, 32'd0);

    // reset after edge 5 with a stray start request while busy
    a5 = 8'hA5;
    d0 = done_count;
    e0 = error_count;
    applyStimulus(a5);
    waitRequest(ok);
    checkOutput("rst_request_reached", {31'd0, ok}, 32'd1);
    tick(2);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        tx_data = 8'h3C;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
      end
      devEdge(s);
      part[i] = s;
    end
    checkOutput("rst_partial_bits", {27'd0, part}, {27'd0, a5[4:0]});
    checkOutput("rst_pre_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_async_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    checkOutput("rst_async_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    tick(3);
    reset = 1'b1;
    tick(100);
    checkOutput("rst_no_restart", {31'd0, ps2_clk_oe}, 32'd0);
    checkOutput("rst_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("rst_no_done", done_count - d0, 32'd0);
    checkOutput("rst_no_error", error_count - e0, 32'd0);

`ifdef PS2_TX_TIMEOUT_EN
    e0 = error_count;
    applyStimulus(8'h12);
    waitRequest(ok);
    checkOutput("wd_request_reached", {31'd0, ok}, 32'd1);
    cnt = 0;
    while (!tx_error && cnt < TB_TIMEOUT + 100) begin
      tick(1);
      cnt++;
    end
    checkOutput("wd_latency", cnt, TB_TIMEOUT);
    checkOutput("wd_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    checkOutput("wd_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    tick(5);
    checkOutput("wd_error_once", error_count - e0, 32'd1);
`endif

    checkOutput("done_err_exclusive", both_count, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
